mmio_bus_master: RTL

//  Initiator side of the memory-mapped I/O bus (0xF0-0xFF peripheral window).
//  - Takes single read/write requests from the CPU core over a valid/ready port.
//  - Drives one-cycle read/write strobes to the MMIO responder and returns the response.
//  - Poll mode re-reads an address until (data & mask) == match, e.g. to wait on UART TX busy.

---
 rtl/mmio_bus_master_pkg.sv | 27 ++
 rtl/mmio_bus_master_poll_ctrl.sv | 57 +++++
 rtl/mmio_bus_master.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mmio_bus_master_pkg.sv
// Shared definitions for the MMIO initiator: I/O window addresses, FSM
// state encoding and the poll compare, so responder and initiator agree.
package mmio_bus_master_pkg;

  localparam logic [7:0] IO_GPIO_BASE = 8'hF0;
  localparam logic [7:0] IO_GPIO_DIR  = 8'hF7;
  localparam logic [7:0] IO_TIMER     = 8'hF8;
  localparam logic [7:0] IO_UART_TX   = 8'hF9;
  localparam logic [7:0] IO_UART_RX   = 8'hFA;
  localparam logic [7:0] IO_STATUS    = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_GAP     = 3'd3,
    ST_RESP    = 3'd4
  } mmio_state_e;

  // Bits outside the mask are ignored; match bits outside the mask never match.
  function automatic logic poll_hit(input logic [7:0] data,
                                    input logic [7:0] mask,
                                    input logic [7:0] match);
    return (data & mask) == match;
  endfunction

endpackage

// File: rtl/mmio_bus_master_poll_ctrl.sv
// Poll bookkeeping: saturating attempt counter, gap down-counter with
// terminal-count compare, and the masked match compare.
module mmio_bus_master_poll_ctrl
  import mmio_bus_master_pkg::*;
#(
  parameter int POLL_LIMIT = 255,
  parameter int POLL_GAP   = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       attempt_inc,
  input  logic       gap_load,
  input  logic       gap_step,
  input  logic [7:0] data,
  input  logic [7:0] mask,
  input  logic [7:0] match,
  output logic       hit,
  output logic       at_limit,
  output logic       gap_done
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(POLL_LIMIT);
  // Loaded with GAP-1 so the GAP state lasts exactly POLL_GAP cycles.
  localparam logic [CNT_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? CNT_W'(POLL_GAP - 1) : '0;

  logic [CNT_W-1:0] attempt_cnt;
  logic [CNT_W-1:0] gap_cnt;

  // Attempt counter: cleared per request, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      attempt_cnt <= '0;
    end else if (clear) begin
      attempt_cnt <= '0;
    end else if (attempt_inc && (attempt_cnt != '1)) begin
      attempt_cnt <= attempt_cnt + 1'b1;
    end
  end

  // Gap timer: down-counter, stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (gap_load) begin
      gap_cnt <= GAP_LOAD;
    end else if (gap_step && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  assign hit      = poll_hit(data, mask, match);
  assign at_limit = attempt_cnt >= LIMIT;
  assign gap_done = gap_cnt == '0;

endmodule

// File: rtl/mmio_bus_master.sv
// MMIO bus initiator: single read/write requests with optional poll-until-match.
//
// state   | meaning
// IDLE    | ready for a request
// ISSUE   | one strobe cycle, responder claim sampled
// CAPTURE | registered read data arrives, poll compare
// GAP     | idle spacing between poll reads
// RESP    | response held until rsp_ready
module mmio_bus_master
  import mmio_bus_master_pkg::*;
#(
  parameter int POLL_LIMIT = 255,
  parameter int POLL_GAP   = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic       req_poll,
  input  logic [7:0] req_mask,
  input  logic [7:0] req_match,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       rsp_timeout,
  output logic [7:0] io_address,
  output logic       io_read_enable,
  output logic       io_write_enable,
  output logic [7:0] io_write_data,
  input  logic [7:0] io_read_data,
  input  logic       io_valid,
  output logic       busy
);

  mmio_state_e state_q, state_d;
  logic       lat_write, lat_poll;
  logic [7:0] lat_addr, lat_wdata, lat_mask, lat_match;
  logic       req_ready_q, accept, in_issue;
  logic       hit, at_limit, gap_done;

  assign in_issue        = state_q == ST_ISSUE;
  assign accept          = (state_q == ST_IDLE) && req_valid && req_ready_q;
  assign req_ready       = req_ready_q;
  assign busy            = state_q != ST_IDLE;
  assign rsp_valid       = state_q == ST_RESP;
  // Strobes and bus fields decode straight from state so reset drops them at once.
  assign io_read_enable  = in_issue && !lat_write;
  assign io_write_enable = in_issue && lat_write;
  assign io_address      = in_issue ? lat_addr  : '0;
  assign io_write_data   = in_issue ? lat_wdata : '0;

  mmio_bus_master_poll_ctrl #(
    .POLL_LIMIT (POLL_LIMIT),
    .POLL_GAP   (POLL_GAP),
    .CNT_W      (CNT_W)
  ) u_poll (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (accept),
    .attempt_inc (io_read_enable && io_valid),
    .gap_load    (state_q == ST_CAPTURE),
    .gap_step    (state_q == ST_GAP),
    .data        (io_read_data),
    .mask        (lat_mask),
    .match       (lat_match),
    .hit         (hit),
    .at_limit    (at_limit),
    .gap_done    (gap_done)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = (lat_write || !io_valid) ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: begin
        if (!lat_poll || hit || at_limit) state_d = ST_RESP;
        else if (POLL_GAP == 0)           state_d = ST_ISSUE;
        else                              state_d = ST_GAP;
      end
      ST_GAP:     if (gap_done) state_d = ST_ISSUE;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State register; req_ready is registered so it reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= state_d == ST_IDLE;
    end
  end

  // Request latch and response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write   <= 1'b0;
      lat_poll    <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_mask    <= '0;
      lat_match   <= '0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (accept) begin
      lat_write   <= req_write;
      lat_poll    <= req_poll && !req_write;
      lat_addr    <= req_addr;
      lat_wdata   <= req_wdata;
      lat_mask    <= req_mask;
      lat_match   <= req_match;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (in_issue && (lat_write || !io_valid)) begin
      rsp_error   <= !io_valid;
    end else if (state_q == ST_CAPTURE) begin
      rsp_rdata   <= io_read_data;
      rsp_timeout <= lat_poll && !hit && at_limit;
    end
  end

endmodule
